clk_div_bank: RTL and testbench



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_channel.sv | 57 +++++
 rtl/clk_div_bank.sv | 56 +++++
 tb/tb_clk_div_bank.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clk_div_pkg;

  localparam int DIV_W_DEF = 32;

  function automatic int def_div(input int clk_hz, input int out_hz);
    return clk_hz / out_hz;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, registered outputs.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int             DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic             o_clk,
  output logic             o_tick,
  output logic             busy
);

  logic [DIV_W-1:0] count, div_act, pend;
  logic [DIV_W-1:0] count_nx, div_nx, pend_nx;
  logic             busy_nx, tick_nx, clk_nx;
  logic             run, wrap, sync_go, apply;

  always_comb begin
    run     = (div_act != '0);
    wrap    = run && (count == div_act - DIV_W'(1));
    sync_go = sync && run;
    // a stopped channel takes its pending divisor right away
    apply   = busy && (!run || wrap || sync_go);
    div_nx  = apply ? pend : div_act;
    count_nx = '0;
    if (run && !wrap && !sync_go && !apply)
      count_nx = count + DIV_W'(1);
    pend_nx = wr ? wr_div : pend;
    busy_nx = wr || (busy && !apply);
    tick_nx = (div_nx != '0) && (count_nx == '0);
    clk_nx  = (div_nx != '0) && (count_nx < (div_nx >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      div_act <= DEF_DIV;
      pend    <= '0;
      busy    <= 1'b0;
      o_clk   <= 1'b0;
      o_tick  <= 1'b0;
    end else begin
      count   <= count_nx;
      div_act <= div_nx;
      pend    <= pend_nx;
      busy    <= busy_nx;
      o_clk   <= clk_nx;
      o_tick  <= tick_nx;
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH runtime-programmable clock dividers with tick strobes.
// Optional CLKDIV_BANK_SYNC_EN adds sync_in to phase-align all channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CLK_HZ = 25000000,
  parameter int OUT_HZ = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [idx_w(NUM_CH)-1:0]  wr_ch,
  input  logic [DIV_W-1:0]          wr_div,
`ifdef CLKDIV_BANK_SYNC_EN
  input  logic                      sync_in,
`endif
  output logic [NUM_CH-1:0]         o_clk,
  output logic [NUM_CH-1:0]         o_tick,
  output logic [NUM_CH-1:0]         busy
);

  localparam int CH_W    = idx_w(NUM_CH);
  localparam int DEF_DIV = def_div(CLK_HZ, OUT_HZ);

  logic sync;

`ifdef CLKDIV_BANK_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;

    // out-of-range channel numbers match no instance
    assign sel = wr_en && (wr_ch == CH_W'(i));

    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DIV_W'(DEF_DIV))
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr     (sel),
      .wr_div (wr_div),
      .sync   (sync),
      .o_clk  (o_clk[i]),
      .o_tick (o_tick[i]),
      .busy   (busy[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised + directed bench for clk_div_bank against a period/phase model.
module tb_clk_div_bank;

  localparam int NC  = 3;
  localparam int DW  = 8;
  localparam int DEF = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          wr_en = 0;
  logic [1:0]    wr_ch = '0;
  logic [DW-1:0] wr_div = '0;
  logic          sync_in = 0;
  logic [NC-1:0] o_clk, o_tick, busy;

  int checks = 0;
  int errors = 0;

  clk_div_bank #(
    .NUM_CH (NC),
    .DIV_W  (DW),
    .CLK_HZ (4),
    .OUT_HZ (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
`ifdef CLKDIV_BANK_SYNC_EN
    .sync_in(sync_in),
`endif
    .o_clk  (o_clk),
    .o_tick (o_tick),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel sits at position pos within a period of length div.
  int m_div[NC], m_pos[NC], m_pend[NC];
  bit m_pv[NC];
  logic [NC-1:0] e_clk, e_tick, e_busy;

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        m_div[i] = DEF; m_pos[i] = 0; m_pv[i] = 0; m_pend[i] = 0;
        e_clk[i] = 0; e_tick[i] = 0; e_busy[i] = 0;
      end else begin
        bit bnd, sy;
        bnd = (m_div[i] != 0) && ((m_pos[i] + 1) % m_div[i] == 0);
        sy  = sync_in && (m_div[i] != 0);
        if (m_pv[i] && (m_div[i] == 0 || bnd || sy)) begin
          m_div[i] = m_pend[i]; m_pv[i] = 0; m_pos[i] = 0;
        end else if (sy || m_div[i] == 0) begin
          m_pos[i] = 0;
        end else begin
          m_pos[i] = (m_pos[i] + 1) % m_div[i];
        end
        if (wr_en && int'(wr_ch) == i) begin
          m_pend[i] = int'(wr_div); m_pv[i] = 1;
        end
        e_tick[i] = (m_div[i] != 0) && (m_pos[i] == 0);
        e_clk[i]  = (m_div[i] != 0) && (m_pos[i] < m_div[i] / 2);
        e_busy[i] = m_pv[i];
      end
    end
    #1;
    chk("model_o_clk",  32'(o_clk),  32'(e_clk));
    chk("model_o_tick", 32'(o_tick), 32'(e_tick));
    chk("model_busy",   32'(busy),   32'(e_busy));
  end

  task automatic wr(input int ch, input int d);
    @(negedge clk);
    wr_en = 1; wr_ch = 2'(ch); wr_div = DW'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic wait_busy(input int ch, input string name);
    for (int n = 0; n < 40; n++) begin
      if (!busy[ch]) return;
      @(posedge clk); #1;
    end
    chk(name, 32'(busy[ch]), 0);
  endtask

  task automatic measure(input int ch, input int per_e, input string name);
    int per, hi, n;
    n = 0;
    while (!o_tick[ch] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    hi = int'(o_clk[ch]);
    per = 0;
    while (per < 40) begin
      @(posedge clk); #1; per++;
      if (o_tick[ch]) break;
      hi += int'(o_clk[ch]);
    end
    chk({name, "_period"}, 32'(per), 32'(per_e));
    chk({name, "_high"},   32'(hi),  32'(per_e / 2));
  endtask

  // Edge k counts from 0 at the first rising edge after release.
  task automatic first_periods(input string tag);
    logic [11:0] t0, c0, t1;
    @(negedge clk) rst = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      t0[k] = o_tick[0]; c0[k] = o_clk[0]; t1[k] = o_tick[1];
    end
    chk({tag, "_tick0"}, 32'(t0), 32'h888);
    chk({tag, "_clk0"},  32'(c0), 32'h999);
    chk({tag, "_tick1"}, 32'(t1), 32'h888);
  endtask

  initial begin
    logic acc;
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({o_clk, o_tick, busy}), 0);
    first_periods("first");

    wr(1, 5);
    chk("wr_busy1", 32'(busy), 32'b010);
    wait_busy(1, "busy1_stuck");
    measure(1, 5, "ch1_div5");
    measure(0, 4, "ch0_div4");

    wr(0, 0);
    wait_busy(0, "busy0_stuck");
    acc = 0;
    repeat (6) begin
      @(posedge clk); #1;
      acc |= o_clk[0] | o_tick[0];
    end
    chk("stopped_outs", 32'(acc), 0);
    wr(0, 3);
    @(posedge clk); #1;
    chk("restart_tick", 32'(o_tick[0]), 1);
    chk("restart_busy", 32'(busy[0]), 0);
    measure(0, 3, "ch0_div3");

    @(negedge clk);
    wr_en = 1; wr_ch = 0; wr_div = 6;
    @(negedge clk);
    wr_div = 7;
    @(negedge clk);
    wr_en = 0;
    wait_busy(0, "busy0_lastwr");
    measure(0, 7, "ch0_last_wins");

    wr(3, 1);
    chk("bad_ch_busy", 32'(busy), 0);
    measure(0, 7, "ch0_after_bad");

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wr_en  = ($urandom_range(0, 5) == 0);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_div = DW'($urandom_range(0, 9));
`ifdef CLKDIV_BANK_SYNC_EN
      sync_in = ($urandom_range(0, 30) == 0);
`endif
    end
    @(negedge clk);
    wr_en = 0; sync_in = 0;

    wr(1, 6);
    rst = 1;
    #1;
    chk("midrst_outs", 32'({o_clk, o_tick, busy}), 0);
    repeat (2) @(negedge clk);
    first_periods("again");

`ifdef CLKDIV_BANK_SYNC_EN
    wr(1, 5);
    wait_busy(1, "sync_busy1");
    repeat (7) @(posedge clk);
    @(negedge clk) sync_in = 1;
    @(posedge clk); #1;
    chk("sync_ticks", 32'(o_tick[1:0]), 32'b11);
    @(negedge clk) sync_in = 0;
    repeat (25) @(posedge clk);
`endif

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
